// File: rtl/stream_distributor.sv
// rtl/stream_distributor.sv - registered 1-to-N valid/ready distributor (directed, round-robin, broadcast, discard)
//
// Ports:
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   enable          gate for accepting new words; held words always drain
//   mode            00 directed, 01 round-robin, 10 broadcast, 11 discard
//   select_line     target channel in directed mode
//   in_valid/in_ready/input_data   producer handshake
//   out_valid/out_ready/out_data   per-channel consumer handshake, lane i at [i*DATA_W +: DATA_W]
//   drop_cnt        saturating count of words accepted with no target channel
module stream_distributor #(
    parameter int  DATA_W = 8,
    parameter int  N_OUT  = 4,
    localparam int SEL_W  = $clog2(N_OUT)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic [1:0]                mode,
    input  logic [SEL_W-1:0]          select_line,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         input_data,
    output logic [N_OUT-1:0]          out_valid,
    input  logic [N_OUT-1:0]          out_ready,
    output logic [N_OUT*DATA_W-1:0]   out_data,
    output logic [15:0]               drop_cnt
);

    localparam logic [1:0] MODE_DIRECTED  = 2'b00;
    localparam logic [1:0] MODE_ROUND     = 2'b01;
    localparam logic [1:0] MODE_BROADCAST = 2'b10;

    logic [N_OUT-1:0]        valid_q, valid_d;
    logic [N_OUT*DATA_W-1:0] data_q, data_d;
    logic [15:0]             drop_cnt_q, drop_cnt_d;
    logic [SEL_W-1:0]        ptr_q, ptr_d;

    logic [N_OUT-1:0]        target;
    logic [N_OUT-1:0]        slot_free;
    logic                    accept;

    // Target set for the word presented this cycle. An out-of-range select
    // simply matches no channel, which turns the word into a drop.
    always_comb begin
        target = '0;
        for (int i = 0; i < N_OUT; i++) begin
            case (mode)
                MODE_DIRECTED:  target[i] = (select_line == SEL_W'(i));
                MODE_ROUND:     target[i] = (ptr_q == SEL_W'(i));
                MODE_BROADCAST: target[i] = 1'b1;
                default:        target[i] = 1'b0;
            endcase
        end
    end

    // A slot may be refilled in the same cycle its current word drains.
    assign slot_free = ~valid_q | out_ready;

    // All targets must be free together so a broadcast never partially lands.
    assign in_ready = rst_n & enable & ~|(target & ~slot_free);
    assign accept   = in_valid & in_ready;

    always_comb begin
        valid_d    = valid_q;
        data_d     = data_q;
        drop_cnt_d = drop_cnt_q;
        ptr_d      = ptr_q;

        for (int i = 0; i < N_OUT; i++) begin
            if (accept && target[i]) begin
                valid_d[i]                  = 1'b1;
                data_d[i*DATA_W +: DATA_W]  = input_data;
            end else if (valid_q[i] && out_ready[i]) begin
                // Drained lanes are zeroed so idle lanes always read 0.
                valid_d[i]                  = 1'b0;
                data_d[i*DATA_W +: DATA_W]  = '0;
            end
        end

        if (accept && (target == '0) && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end

        if (accept && (mode == MODE_ROUND)) begin
            if (ptr_q == SEL_W'(N_OUT - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= '0;
            data_q     <= '0;
            drop_cnt_q <= '0;
            ptr_q      <= '0;
        end else begin
            valid_q    <= valid_d;
            data_q     <= data_d;
            drop_cnt_q <= drop_cnt_d;
            ptr_q      <= ptr_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_stream_distributor.sv
// tb/tb_stream_distributor.sv - self-checking bench for stream_distributor (N_OUT=4 main build, N_OUT=3 drop build)
module tb_stream_distributor;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        enable;
    logic [1:0]  mode;
    logic [1:0]  select_line;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  input_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] out_data;
    logic [15:0] drop_cnt;

    logic        enable3;
    logic [1:0]  mode3;
    logic [1:0]  select3;
    logic        in_valid3;
    logic        in_ready3;
    logic [7:0]  input_data3;
    logic [2:0]  out_valid3;
    logic [2:0]  out_ready3;
    logic [23:0] out_data3;
    logic [15:0] drop_cnt3;

    int vec_cnt = 0;
    int err_cnt = 0;

    // Reference state: one holding slot per channel, rotation pointer, drop count.
    bit       mv[4];
    bit [7:0] md[4];
    int       mptr;
    int       mdrop;

    always #5 clk = ~clk;

    stream_distributor #(.DATA_W(8), .N_OUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode),
        .select_line(select_line), .in_valid(in_valid), .in_ready(in_ready),
        .input_data(input_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .drop_cnt(drop_cnt)
    );

    stream_distributor #(.DATA_W(8), .N_OUT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .enable(enable3), .mode(mode3),
        .select_line(select3), .in_valid(in_valid3), .in_ready(in_ready3),
        .input_data(input_data3), .out_valid(out_valid3), .out_ready(out_ready3),
        .out_data(out_data3), .drop_cnt(drop_cnt3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            mv[i] = 1'b0;
            md[i] = 8'h00;
        end
        mptr  = 0;
        mdrop = 0;
    endtask

    task automatic check_outputs();
        logic [3:0] ev;
        for (int i = 0; i < 4; i++) begin
            ev[i] = mv[i];
            chk($sformatf("lane%0d", i), {24'h0, out_data[i*8 +: 8]}, {24'h0, md[i]});
        end
        chk("out_valid", {28'h0, out_valid}, {28'h0, ev});
        chk("drop_cnt", {16'h0, drop_cnt}, mdrop);
    endtask

    // One clock of traffic on the N_OUT=4 build: check held state, drive,
    // check in_ready, advance the reference, take the edge.
    task automatic step(input bit e, input logic [1:0] m, input logic [1:0] s,
                        input bit v, input logic [7:0] d, input logic [3:0] r);
        logic [3:0] tgt;
        bit         rdy;
        bit         acc;
        @(negedge clk);
        check_outputs();
        enable = e; mode = m; select_line = s; in_valid = v; input_data = d; out_ready = r;
        #1;
        case (m)
            2'b00:   tgt = 4'b0001 << s;
            2'b01:   tgt = 4'b0001 << mptr;
            2'b10:   tgt = 4'b1111;
            default: tgt = 4'b0000;
        endcase
        rdy = e;
        for (int i = 0; i < 4; i++) begin
            if (tgt[i] && mv[i] && !r[i]) rdy = 1'b0;
        end
        chk("in_ready", {31'h0, in_ready}, {31'h0, rdy});
        acc = v && rdy;
        for (int i = 0; i < 4; i++) begin
            if (acc && tgt[i]) begin
                mv[i] = 1'b1;
                md[i] = d;
            end else if (mv[i] && r[i]) begin
                mv[i] = 1'b0;
                md[i] = 8'h00;
            end
        end
        if (acc && tgt == 4'b0000 && mdrop < 65535) mdrop++;
        if (acc && m == 2'b01) mptr = (mptr + 1) % 4;
        @(posedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        enable = 0; mode = 0; select_line = 0; in_valid = 0; input_data = 0; out_ready = 0;
        enable3 = 0; mode3 = 0; select3 = 0; in_valid3 = 0; input_data3 = 0; out_ready3 = 0;
        model_reset();
        #12;
        chk("reset_valid", {28'h0, out_valid}, 32'h0);
        chk("reset_data", out_data, 32'h0);
        chk("reset_ready", {31'h0, in_ready}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed to channel 2, then drained.
        step(1, 2'b00, 2'd2, 1, 8'hA5, 4'hF);
        #2;
        chk("dir_valid", {28'h0, out_valid}, 32'h4);
        chk("dir_data", out_data, 32'h00A50000);
        step(1, 2'b00, 2'd0, 0, 8'h00, 4'hF);
        #2;
        chk("dir_drain", {28'h0, out_valid}, 32'h0);

        // Round-robin wrap: channels 0,1,2,3,0 then pointer at 1.
        for (int k = 0; k < 5; k++) begin
            step(1, 2'b01, 2'd0, 1, 8'h10 + 8'(k), 4'hF);
            #2;
            chk("rr_valid", {28'h0, out_valid}, 32'h1 << (k % 4));
            chk("rr_data", out_data, (32'h10 + k) << (8 * (k % 4)));
        end
        step(1, 2'b01, 2'd0, 1, 8'h15, 4'hF);
        #2;
        chk("rr_ptr", {28'h0, out_valid}, 32'h2);

        // Backpressure on channel 1 while channel 3 still accepts.
        step(1, 2'b00, 2'd1, 1, 8'h11, 4'hF);
        step(1, 2'b00, 2'd1, 1, 8'h22, 4'b1101);
        #2;
        chk("bp_hold", {24'h0, out_data[15:8]}, 32'h11);
        step(1, 2'b00, 2'd3, 1, 8'h33, 4'b1101);
        step(1, 2'b00, 2'd1, 1, 8'h22, 4'hF);
        #2;
        chk("bp_release", {24'h0, out_data[15:8]}, 32'h22);

        // Broadcast stalled by channel 0, then all four lanes load together.
        step(1, 2'b00, 2'd0, 1, 8'h55, 4'hF);
        step(1, 2'b10, 2'd0, 1, 8'h3C, 4'b1110);
        #2;
        chk("bc_stall", {24'h0, out_data[7:0]}, 32'h55);
        step(1, 2'b10, 2'd0, 1, 8'h3C, 4'hF);
        #2;
        chk("bc_valid", {28'h0, out_valid}, 32'hF);
        chk("bc_data", out_data, 32'h3C3C3C3C);

        // Discard mode.
        for (int k = 0; k < 3; k++) step(1, 2'b11, 2'd0, 1, 8'h77, 4'hF);
        #2;
        chk("discard_cnt", {16'h0, drop_cnt}, 32'd3);

        // Enable low blocks new words.
        step(0, 2'b00, 2'd0, 1, 8'h99, 4'hF);

        // Reset mid-traffic with out_valid = 0101.
        step(1, 2'b00, 2'd0, 1, 8'h01, 4'h0);
        step(1, 2'b00, 2'd2, 1, 8'h02, 4'h0);
        #2;
        chk("pre_rst_valid", {28'h0, out_valid}, 32'h5);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {28'h0, out_valid}, 32'h0);
        chk("mid_rst_data", out_data, 32'h0);
        chk("mid_rst_drop", {16'h0, drop_cnt}, 32'h0);
        chk("mid_rst_ready", {31'h0, in_ready}, 32'h0);
        model_reset();
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic against the reference.
        for (int k = 0; k < 1500; k++) begin
            step($urandom_range(0, 7) != 0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 $urandom_range(0, 3) != 0, 8'($urandom), 4'($urandom));
        end
        step(1, 2'b00, 2'd0, 0, 8'h00, 4'hF);
        step(1, 2'b00, 2'd0, 0, 8'h00, 4'hF);

        // N_OUT=3: out-of-range select drops, in-range select delivers.
        @(negedge clk);
        enable3 = 1; mode3 = 2'b00; select3 = 2'd3; in_valid3 = 1; input_data3 = 8'hE1; out_ready3 = 3'b111;
        #1;
        chk("n3_oor_ready", {31'h0, in_ready3}, 32'h1);
        @(negedge clk);
        chk("n3_oor_drop", {16'h0, drop_cnt3}, 32'd1);
        chk("n3_oor_valid", {29'h0, out_valid3}, 32'h0);
        select3 = 2'd2; input_data3 = 8'hE2;
        @(negedge clk);
        chk("n3_dir_valid", {29'h0, out_valid3}, 32'h4);
        chk("n3_dir_data", {8'h0, out_data3}, 32'h00E20000);

        // Saturation: drive discards until the counter pins at FFFF.
        mode3 = 2'b11;
        repeat (65533) @(posedge clk);
        #2;
        chk("n3_near_max", {16'h0, drop_cnt3}, 32'hFFFE);
        @(posedge clk);
        #2;
        chk("n3_max", {16'h0, drop_cnt3}, 32'hFFFF);
        repeat (3) @(posedge clk);
        #2;
        chk("n3_saturate", {16'h0, drop_cnt3}, 32'hFFFF);
        chk("n3_sat_ready", {31'h0, in_ready3}, 32'h1);
        in_valid3 = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/stream_distributor.md
Name: stream_distributor

Overview:
Registered 1-to-N data distributor with valid/ready handshaking on the input and on every output channel. Each word goes to one channel chosen by a select input (directed), to the next channel in rotation (round-robin), or to all channels at once (broadcast). Each output channel has a one-entry holding register, so one channel stalling does not corrupt the others. Sits between a single producer and N consumer blocks in the datapath.

Parameters:
DATA_W, 8, width of each data word
N_OUT, 4, number of output channels; legal range 2..16
SEL_W, $clog2(N_OUT), select width; derived, not overridden

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
enable  input  1  when low, no new words are accepted; held words still drain
mode  input  2  00 directed, 01 round-robin, 10 broadcast, 11 discard
select_line  input  SEL_W  target channel in directed mode
in_valid  input  1  input word valid
in_ready  output  1  distributor can accept the input word this cycle
input_data  input  DATA_W  input word
out_valid  output  N_OUT  per-channel valid; bit i belongs to channel i
out_ready  input  N_OUT  per-channel consumer ready
out_data  output  N_OUT*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W]
drop_cnt  output  16  number of words discarded since reset; saturates at 16'hFFFF

Behaviour:
- Reset, asynchronous, when rst_n is low: out_valid=0, every out_data lane=0, drop_cnt=0, round-robin pointer=0. in_ready is combinational and reads 0 while in reset.
- A channel slot is free when out_valid[i]=0 or out_ready[i]=1 in the same cycle. Draining and refilling a slot in one cycle is allowed.
- The target set is taken from mode in the current cycle:
  - directed: {select_line}
  - round-robin: {ptr}
  - broadcast: all channels
  - discard: none
  - directed with select_line >= N_OUT: none
- in_ready = enable AND every slot in the target set is free. An empty target set gives in_ready = enable.
- Accept: in_valid AND in_ready at a rising edge.
  - Every target slot loads input_data and sets out_valid[i] on the next edge.
  - Latency is 1 cycle from accept to out_valid.
- An accept with an empty target set drops the word and increments drop_cnt. The counter saturates at 16'hFFFF and never wraps.
- A slot with out_valid[i]=1 AND out_ready[i]=1 that is not reloaded clears out_valid[i] and zeroes its out_data lane. Idle lanes always read 0.
- While out_valid[i]=1 and out_ready[i]=0, that lane's out_data and out_valid stay stable.
- Round-robin pointer:
  - Advances only on an accept in mode 01, from N_OUT-1 wraps to 0.
  - Holds its value in all other modes and across mode changes.
- Broadcast loads all channels in the same cycle. Partial delivery is never allowed.
- enable low: in_ready=0. Existing held words keep draining normally.
- mode and select_line are only meaningful during an accept. Changing them while stalled affects only the next accept.
- Throughput: one word per cycle when the targeted consumers keep out_ready=1.

Test Plan:
- Reset mid-traffic: assert rst_n=0 while out_valid=4'b0101 -> out_valid=0, all lanes 0, drop_cnt=0 immediately, with no clock edge needed.
- Directed: mode=00, select_line=2, input_data=8'hA5, out_ready=4'hF -> one cycle later out_valid=4'b0100, lane2=8'hA5, other lanes 0; the next cycle out_valid=0.
- Round-robin wrap: mode=01, push 8'h10..8'h14 back-to-back with all ready -> channels 0,1,2,3,0 in order, one word per cycle, pointer ends at 1.
- Backpressure: directed to channel 1 with out_ready[1]=0 and a second word to channel 1 pending -> in_ready=0 and lane1 holds the first word. Meanwhile a word directed to channel 3 is accepted. Raise out_ready[1] -> the second word loads on that same edge.
- Broadcast stall: mode=10 with out_valid[0]=1 and out_ready[0]=0 -> in_ready=0 and no lane changes. Release out_ready[0] -> all 4 lanes load 8'h3C together.
- Discard and saturation: mode=11, or mode=00 with an out-of-range select_line on a non-power-of-two N_OUT=3 build -> in_ready=1 and drop_cnt increments per word. Preload drop_cnt near max and push 3 more -> it stays at 16'hFFFF.
